// File: rtl/matrix_fp_pkg.sv
`default_nettype none
//============================================================================
// Module   : matrix_fp_pkg
// Brief    : Shared fixed-point matrix constants, op/state encodings, clamp.
// Revision : 1.0 - initial release
//============================================================================
package matrix_fp_pkg;

    localparam int DEF_INT_WIDTH  = 8;
    localparam int DEF_FRAC_WIDTH = 8;
    localparam int TOTAL_WIDTH    = DEF_INT_WIDTH + DEF_FRAC_WIDTH;
    localparam int MAX_WIDTH      = 64;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_RSUB = 2'b10;
    localparam logic [1:0] OP_COPY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROCESS = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // ext holds a w+1 bit result sign-extended to MAX_WIDTH+1; the caller keeps the low w bits.
    function automatic logic [MAX_WIDTH-1:0] sat_clamp(input logic [MAX_WIDTH:0] ext,
                                                       input logic [6:0]         w);
        logic [MAX_WIDTH-1:0] lim;
        logic [6:0]           msb;
        msb = w - 7'd1;
        lim = ext[MAX_WIDTH-1:0];
        if (ext[w] != ext[msb]) begin
            lim = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << msb;
            if (!ext[w]) begin
                lim = lim - {{(MAX_WIDTH-1){1'b0}}, 1'b1};
            end
        end
        return lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_lane.sv
`default_nettype none
//============================================================================
// Module   : fp_addsub_lane
// Brief    : One combinational signed add/sub/rsub/copy lane with overflow.
// Revision : 1.0 - initial release
//============================================================================
module fp_addsub_lane
    import matrix_fp_pkg::*;
#(
    parameter int W        = TOTAL_WIDTH,
    parameter bit SATURATE = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] sum_w,
    output logic         ovf
);

    logic [W:0] w_a;
    logic [W:0] w_b;
    logic [W:0] w_s;

    assign w_a = {a[W-1], a};
    assign w_b = {b[W-1], b};

    always_comb begin
        w_s = w_a;
        case (op)
            OP_SUB:  w_s = w_a - w_b;
            OP_ADD:  w_s = w_a + w_b;
            OP_RSUB: w_s = w_b - w_a;
            default: w_s = w_a;
        endcase
    end

    assign ovf = w_s[W] ^ w_s[W-1];

    generate
        if (SATURATE) begin : g_sat
            logic [MAX_WIDTH:0] w_ext;
            assign w_ext = {{(MAX_WIDTH-W){w_s[W]}}, w_s};
            assign sum_w = W'(sat_clamp(w_ext, 7'(W)));
        end else begin : g_wrap
            assign sum_w = w_s[W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/matrix_addsub_fixed_point.sv
`default_nettype none
//============================================================================
// Module   : matrix_addsub_fixed_point
// Brief    : Element-wise A-B / A+B / B-A / copy over a fixed-point matrix.
// Revision : 1.0 - initial release
//============================================================================
module matrix_addsub_fixed_point
    import matrix_fp_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int LANES      = 1,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic [1:0]                                    op,
    input  logic [ROWS*COLS*(INT_WIDTH+FRAC_WIDTH)-1:0]   matrix_a,
    input  logic [ROWS*COLS*(INT_WIDTH+FRAC_WIDTH)-1:0]   matrix_b,
    output logic [ROWS*COLS*(INT_WIDTH+FRAC_WIDTH)-1:0]   result,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overflow
);

    localparam int c_W     = INT_WIDTH + FRAC_WIDTH;
    localparam int c_N     = ROWS * COLS;
    localparam int c_BEATS = c_N / LANES;
    localparam int c_CW    = $clog2(c_BEATS) + 1;

    generate
        if (LANES < 1 || (c_N % LANES) != 0 || c_W >= MAX_WIDTH) begin : g_param_check
            $error("matrix_addsub_fixed_point: ROWS*COLS must be a multiple of LANES");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CW-1:0]        r_beat;
    logic [1:0]             r_op;
    logic                   r_ovf;
    logic [c_N*c_W-1:0]     r_res;
    logic [LANES*c_W-1:0]   w_lsum;
    logic [LANES-1:0]       w_lovf;
    logic                   w_accept;
    logic                   w_last;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_beat == c_CW'(c_BEATS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start)  w_state_nxt = ST_PROCESS;
            ST_PROCESS: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:                w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_op    <= OP_SUB;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= op;
                r_beat <= '0;
                r_ovf  <= 1'b0;
            end else if (r_state == ST_PROCESS) begin
                r_beat <= r_beat + c_CW'(1);
                if (|w_lovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Each lane picks its operand for the current beat straight off the live input buses.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [c_W-1:0] w_a_sel;
            logic [c_W-1:0] w_b_sel;

            always_comb begin
                w_a_sel = '0;
                w_b_sel = '0;
                for (int bt = 0; bt < c_BEATS; bt++) begin
                    if (r_beat == c_CW'(bt)) begin
                        w_a_sel = matrix_a[(bt*LANES+l)*c_W +: c_W];
                        w_b_sel = matrix_b[(bt*LANES+l)*c_W +: c_W];
                    end
                end
            end

            fp_addsub_lane #(
                .W        (c_W),
                .SATURATE (SATURATE)
            ) u_lane (
                .a     (w_a_sel),
                .b     (w_b_sel),
                .op    (r_op),
                .sum_w (w_lsum[l*c_W +: c_W]),
                .ovf   (w_lovf[l])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_res <= '0;
        end else if (r_state == ST_PROCESS) begin
            for (int k = 0; k < c_N; k++) begin
                if (r_beat == c_CW'(k / LANES)) begin
                    r_res[k*c_W +: c_W] <= w_lsum[(k%LANES)*c_W +: c_W];
                end
            end
        end
    end

    assign result   = r_res;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_matrix_addsub_fixed_point.sv
`default_nettype none
//============================================================================
// Module   : tb_matrix_addsub_fixed_point
// Brief    : Randomised and directed bench for three matrix_addsub configs.
// Revision : 1.0 - initial release
//============================================================================
module tb_matrix_addsub_fixed_point;

    localparam int c_N  = 16;
    localparam int c_W  = 16;
    localparam int c_BW = c_N * c_W;
    localparam int c_NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            r_start [c_NI];
    logic [1:0]      r_op    [c_NI];
    logic [c_BW-1:0] r_a     [c_NI];
    logic [c_BW-1:0] r_b     [c_NI];
    logic [c_BW-1:0] w_res   [c_NI];
    logic            w_busy  [c_NI];
    logic            w_done  [c_NI];
    logic            w_ovf   [c_NI];

    matrix_addsub_fixed_point #(.ROWS(4), .COLS(4), .INT_WIDTH(8), .FRAC_WIDTH(8),
                                .LANES(1), .SATURATE(1'b1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .start(r_start[0]), .op(r_op[0]),
        .matrix_a(r_a[0]), .matrix_b(r_b[0]), .result(w_res[0]),
        .busy(w_busy[0]), .done(w_done[0]), .overflow(w_ovf[0]));

    matrix_addsub_fixed_point #(.ROWS(4), .COLS(4), .INT_WIDTH(8), .FRAC_WIDTH(8),
                                .LANES(4), .SATURATE(1'b0)) u_dut_l4 (
        .clk(clk), .reset_n(reset_n), .start(r_start[1]), .op(r_op[1]),
        .matrix_a(r_a[1]), .matrix_b(r_b[1]), .result(w_res[1]),
        .busy(w_busy[1]), .done(w_done[1]), .overflow(w_ovf[1]));

    matrix_addsub_fixed_point #(.ROWS(4), .COLS(4), .INT_WIDTH(8), .FRAC_WIDTH(8),
                                .LANES(16), .SATURATE(1'b1)) u_dut_l16 (
        .clk(clk), .reset_n(reset_n), .start(r_start[2]), .op(r_op[2]),
        .matrix_a(r_a[2]), .matrix_b(r_b[2]), .result(w_res[2]),
        .busy(w_busy[2]), .done(w_done[2]), .overflow(w_ovf[2]));

    // Reference model state: cycle numbers of the accepted start, last busy cycle, done cycle.
    int              cyc = 0;
    int              exp_t0     [c_NI];
    int              exp_end    [c_NI];
    int              exp_done   [c_NI];
    int              exp_stable [c_NI];
    logic [c_BW-1:0] exp_res    [c_NI];
    logic            exp_ovf    [c_NI];
    int              busy_cnt   [c_NI];
    int              done_cnt   [c_NI];
    int              last_done  [c_NI];
    bit              chk_en = 1'b0;
    int              n_checks = 0;
    int              n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int beats(input int i);
        return (i == 0) ? 16 : (i == 1) ? 4 : 1;
    endfunction

    function automatic bit sat_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [c_BW-1:0] fill(input logic [15:0] v);
        return {c_N{v}};
    endfunction

    // Returns {overflow, value} computed with plain integer arithmetic.
    function automatic logic [16:0] model_el(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op, input bit sat);
        int sa, sb, r;
        bit ov;
        logic [15:0] v;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00:   r = sa - sb;
            2'b01:   r = sa + sb;
            2'b10:   r = sb - sa;
            default: r = sa;
        endcase
        ov = (r > 32767) || (r < -32768);
        v  = r[15:0];
        if (ov && sat) v = (r > 0) ? 16'h7FFF : 16'h8000;
        return {ov, v};
    endfunction

    task automatic check_v(input string name, input logic [c_BW-1:0] act, input logic [c_BW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    task automatic check_i(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < c_NI; i++) begin
                if (w_busy[i] === 1'b1) busy_cnt[i]++;
                if (w_done[i] === 1'b1) begin
                    done_cnt[i]++;
                    last_done[i] = cyc;
                end
                check_b($sformatf("busy[%0d]@%0d", i, cyc), w_busy[i],
                        (exp_t0[i] < cyc) && (cyc <= exp_end[i]));
                check_b($sformatf("done[%0d]@%0d", i, cyc), w_done[i], cyc == exp_done[i]);
                if (cyc >= exp_stable[i]) begin
                    check_v($sformatf("result[%0d]@%0d", i, cyc), w_res[i], exp_res[i]);
                    check_b($sformatf("overflow[%0d]@%0d", i, cyc), w_ovf[i], exp_ovf[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_release();
        tick();
        for (int i = 0; i < c_NI; i++) r_start[i] = 1'b0;
    endtask

    // Drive start for this cycle; the model accepts it only when the block is idle.
    task automatic arm(input int i, input logic [1:0] op, input logic [c_BW-1:0] a,
                       input logic [c_BW-1:0] b);
        logic [16:0] e;
        bit any;
        r_start[i] = 1'b1;
        r_op[i]    = op;
        if (cyc > exp_end[i]) begin
            r_a[i] = a;
            r_b[i] = b;
            any = 1'b0;
            for (int k = 0; k < c_N; k++) begin
                e = model_el(a[k*16 +: 16], b[k*16 +: 16], op, sat_of(i));
                exp_res[i][k*16 +: 16] = e[15:0];
                any |= e[16];
            end
            exp_ovf[i]    = any;
            exp_t0[i]     = cyc;
            exp_end[i]    = cyc + beats(i) + 1;
            exp_done[i]   = exp_end[i];
            exp_stable[i] = exp_end[i];
            busy_cnt[i]   = 0;
            done_cnt[i]   = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < c_NI; i++) begin
            if (exp_end[i] > cyc) exp_end[i] = cyc;
            if (exp_done[i] > cyc) exp_done[i] = -1;
            exp_stable[i] = cyc + 1;
            exp_res[i]    = '0;
            exp_ovf[i]    = 1'b0;
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input int i);
        int guard;
        guard = 0;
        while (cyc <= exp_end[i] && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check_i($sformatf("idle_timeout[%0d]", i), guard, 0);
    endtask

    function automatic logic [15:0] rand_el();
        case ($urandom_range(3))
            0:       return 16'($urandom);
            1:       return 16'h7FFF - 16'($urandom_range(255));
            2:       return 16'h8000 + 16'($urandom_range(255));
            default: return 16'($urandom_range(511));
        endcase
    endfunction

    function automatic logic [c_BW-1:0] rand_mat();
        logic [c_BW-1:0] m;
        for (int k = 0; k < c_N; k++) m[k*16 +: 16] = rand_el();
        return m;
    endfunction

    initial begin
        logic [c_BW-1:0] ma, mb;
        logic [16:0]     e;
        int              t0;

        reset_n = 1'b0;
        for (int i = 0; i < c_NI; i++) begin
            r_start[i] = 1'b0; r_op[i] = 2'b00; r_a[i] = '0; r_b[i] = '0;
            exp_t0[i] = -100; exp_end[i] = -1; exp_done[i] = -1; exp_stable[i] = 1 << 30;
            exp_res[i] = '0; exp_ovf[i] = 1'b0;
            busy_cnt[i] = 0; done_cnt[i] = 0; last_done[i] = -1;
        end
        tick();
        do_reset();
        chk_en = 1'b1;

        // Model pinned by hand-computed values.
        e = model_el(16'h7F00, 16'h0200, 2'b01, 1'b1); check_v("model_add_sat", c_BW'(e), c_BW'(17'h17FFF));
        e = model_el(16'h7F00, 16'h0200, 2'b01, 1'b0); check_v("model_add_wrap", c_BW'(e), c_BW'(17'h18100));
        e = model_el(16'h0100, 16'hFF00, 2'b10, 1'b1); check_v("model_rsub", c_BW'(e), c_BW'(17'h0FE00));
        e = model_el(16'h8000, 16'h0001, 2'b11, 1'b1); check_v("model_copy", c_BW'(e), c_BW'(17'h08000));

        // 1.5 - 0.5 with one lane.
        t0 = cyc;
        arm(0, 2'b00, fill(16'h0180), fill(16'h0080));
        tick_release();
        wait_idle(0);
        check_i("t1_latency", last_done[0] - t0, 17);
        check_i("t1_busy_cycles", busy_cnt[0], 17);
        check_v("t1_result", w_res[0], fill(16'h0100));
        check_b("t1_overflow", w_ovf[0], 1'b0);

        // 127.0 + 2.0, saturating and wrapping.
        ma = '0; mb = '0; ma[15:0] = 16'h7F00; mb[15:0] = 16'h0200;
        arm(0, 2'b01, ma, mb);
        arm(1, 2'b01, ma, mb);
        tick_release();
        wait_idle(0);
        check_v("t2_sat_result", w_res[0], c_BW'(16'h7FFF));
        check_b("t2_sat_overflow", w_ovf[0], 1'b1);
        check_v("t2_wrap_result", w_res[1], c_BW'(16'h8100));
        check_b("t2_wrap_overflow", w_ovf[1], 1'b1);

        // Reverse subtract then copy on four lanes.
        t0 = cyc;
        arm(1, 2'b10, fill(16'h0100), fill(16'hFF00));
        tick_release();
        wait_idle(1);
        check_i("t3_latency", last_done[1] - t0, 5);
        check_v("t3_rsub_result", w_res[1], fill(16'hFE00));
        check_b("t3_rsub_overflow", w_ovf[1], 1'b0);
        ma = rand_mat();
        arm(1, 2'b11, ma, fill(16'h1234));
        tick_release();
        wait_idle(1);
        check_v("t3_copy_result", w_res[1], ma);
        check_b("t3_copy_overflow", w_ovf[1], 1'b0);

        // Starts while busy and in the DONE cycle are ignored.
        t0 = cyc;
        arm(0, 2'b01, fill(16'h0100), fill(16'h0100));
        tick_release();
        while (cyc < t0 + 3) tick();
        arm(0, 2'b11, r_a[0], r_b[0]);
        tick_release();
        while (cyc < t0 + 17) tick();
        arm(0, 2'b11, r_a[0], r_b[0]);
        tick_release();
        check_i("t4_cycle", cyc, t0 + 18);
        check_i("t4_done_pulses", done_cnt[0], 1);
        check_v("t4_result", w_res[0], fill(16'h0200));
        arm(0, 2'b00, fill(16'h0100), fill(16'h0100));
        tick_release();
        check_b("t4_reaccepted_busy", w_busy[0], 1'b1);
        wait_idle(0);
        check_v("t4_second_result", w_res[0], fill(16'h0000));

        // Reset during beat 7 aborts the operation.
        t0 = cyc;
        arm(0, 2'b00, fill(16'h0300), fill(16'h0100));
        tick_release();
        while (cyc < t0 + 8) tick();
        do_reset();
        check_b("t5_busy_after_reset", w_busy[0], 1'b0);
        check_v("t5_result_after_reset", w_res[0], '0);
        repeat (20) tick();
        check_i("t5_no_done", done_cnt[0], 0);
        arm(0, 2'b00, fill(16'h0300), fill(16'h0100));
        tick_release();
        wait_idle(0);
        check_v("t5_result_restart", w_res[0], fill(16'h0200));

        // Back-to-back on sixteen lanes: overflowing op then a clean one.
        t0 = cyc;
        arm(2, 2'b01, fill(16'h7F00), fill(16'h0200));
        tick_release();
        wait_idle(2);
        check_i("t6_latency", last_done[2] - t0, 2);
        check_b("t6_first_overflow", w_ovf[2], 1'b1);
        arm(2, 2'b00, fill(16'h0001), fill(16'h0001));
        tick_release();
        wait_idle(2);
        check_b("t6_second_overflow", w_ovf[2], 1'b0);
        check_v("t6_second_result", w_res[2], '0);

        // Random traffic, including ignored starts with changed op.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < c_NI; i++) begin
                if (cyc > exp_end[i]) begin
                    if ($urandom_range(2) == 0)
                        arm(i, 2'($urandom), rand_mat(), rand_mat());
                end else if ($urandom_range(5) == 0) begin
                    arm(i, 2'($urandom), r_a[i], r_b[i]);
                end
            end
            tick_release();
        end
        for (int i = 0; i < c_NI; i++) wait_idle(i);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
